// File: rtl/pc_counter.sv
// Free-running program counter: q advances by one, modulo 2^WIDTH, on every rising clk edge.
// Clearing reset (active-low) forces q to zero at once; data_in is held in reserve for a future load/jump.
module pc_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // data_in is a reserved port with no effect on q in this revision; fold it so it stays visibly unused.
  logic unused_data_in;
  assign unused_data_in = ^data_in;

  // Unsigned WIDTH-bit add: the carry falls off, so all-ones wraps to zero.
  always_comb begin
    count_d = count_q + WIDTH'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign q = count_q;

endmodule

// File: tb/tb_pc_counter.sv
// Self-checking bench for pc_counter: a modulo-16 model pushes the expected q on each rising edge,
// and each test pops and compares that value on the following falling edge.
module tb_pc_counter;

  localparam int W = 4;

  logic         clk;
  logic         reset;
  logic [W-1:0] data_in;
  logic [W-1:0] q;

  int errors = 0;
  int checks = 0;
  int exp_cnt = 0;
  logic [W-1:0] sb_q [$];
  logic [W-1:0] got;
  logic [W-1:0] exp_v;
  logic [W-1:0] seq_a [10];
  logic [W-1:0] seq_b [10];

  pc_counter #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .data_in(data_in),
    .q      (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #90000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  // One rising edge: push the model's next value, optionally wiggle data_in mid-cycle,
  // then park on the falling edge so the caller can pop and compare.
  task automatic step(input bit rand_din);
    if (rand_din) data_in = W'($urandom);
    @(posedge clk);
    exp_cnt = (exp_cnt + 1) % (1 << W);
    sb_q.push_back(W'(exp_cnt));
    #2;
    if (rand_din) data_in = W'($urandom);
    @(negedge clk);
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset   = 1'b1;
    exp_cnt = 0;
    sb_q.delete();
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    data_in = '0;
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (q !== 4'b0000) begin
      errors++;
      $display("FAIL reset_initial: q=%b expected 0000", q);
    end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1 data_in = W'($urandom);
      @(negedge clk);
      data_in = W'($urandom);
      checks++;
      if (q !== 4'b0000) begin
        errors++;
        $display("FAIL hold_in_reset[%0d]: q=%b expected 0000", i, q);
      end
    end
  endtask

  task automatic test_count();
    release_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b0);
      got   = q;
      exp_v = sb_q.pop_front();
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL count_seq[%0d]: q=%b expected %b", i, got, exp_v);
      end
    end
    // Sitting midway between edges at q=0101: clear must be immediate.
    reset = 1'b0;
    #1;
    checks++;
    if (q !== 4'b0000) begin
      errors++;
      $display("FAIL async_clear: q=%b expected 0000", q);
    end
  endtask

  task automatic test_wrap();
    release_reset();
    for (int i = 1; i <= 31; i++) begin
      step(1'b1);
      got   = q;
      exp_v = sb_q.pop_front();
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL wrap_edge[%0d]: q=%b expected %b", i, got, exp_v);
      end
    end
    // 16 edges gave 0000, 17 gave 0001; 31 edges leave q at 1111.
    reset = 1'b0;
    #1;
    checks++;
    if (q !== 4'b0000) begin
      errors++;
      $display("FAIL reset_mid_wrap: q=%b expected 0000", q);
    end
    @(posedge clk);
    #1;
    checks++;
    if (q !== 4'b0000) begin
      errors++;
      $display("FAIL reset_mid_wrap_edge: q=%b expected 0000", q);
    end
    release_reset();
    step(1'b0);
    got   = q;
    exp_v = sb_q.pop_front();
    checks++;
    if (got !== exp_v || got !== 4'b0001) begin
      errors++;
      $display("FAIL after_release_first: q=%b expected 0001", got);
    end
  endtask

  task automatic test_data_in();
    @(negedge clk);
    reset = 1'b0;
    data_in = '0;
    release_reset();
    for (int i = 0; i < 10; i++) begin
      step(1'b0);
      seq_a[i] = q;
      exp_v    = sb_q.pop_front();
      checks++;
      if (seq_a[i] !== exp_v) begin
        errors++;
        $display("FAIL din_zero[%0d]: q=%b expected %b", i, seq_a[i], exp_v);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    release_reset();
    for (int i = 0; i < 10; i++) begin
      step(1'b1);
      seq_b[i] = q;
      exp_v    = sb_q.pop_front();
      checks++;
      if (seq_b[i] !== exp_v || seq_b[i] !== seq_a[i]) begin
        errors++;
        $display("FAIL din_random[%0d]: q=%b expected %b (zero-run %b)", i, seq_b[i], exp_v, seq_a[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    // Two short resets in a row, each followed by a fresh count from 1.
    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      reset = 1'b0;
      #1;
      checks++;
      if (q !== 4'b0000) begin
        errors++;
        $display("FAIL b2b_clear[%0d]: q=%b expected 0000", r, q);
      end
      release_reset();
      for (int i = 0; i < 3; i++) begin
        step(1'b1);
        got   = q;
        exp_v = sb_q.pop_front();
        checks++;
        if (got !== exp_v) begin
          errors++;
          $display("FAIL b2b_count[%0d][%0d]: q=%b expected %b", r, i, got, exp_v);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_hold();
    test_count();
    test_wrap();
    test_data_in();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
